keccak_word_streamer: RTL and testbench

//  Downstream companion to the 512-bit word divider. Captures one 512-bit Keccak block/digest and

---
 rtl/keccak_word_streamer.sv | 83 ++++++++
 tb/tb_keccak_word_streamer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/keccak_word_streamer.sv
// Captures one 512-bit Keccak block and streams it out as 32-bit words over a
// valid/ready handshake, most-significant word first, with an internal word index.
module keccak_word_streamer #(
  parameter  int IN_W  = 512,
  parameter  int OUT_W = 32,
  localparam int NW    = IN_W / OUT_W,
  localparam int IDX_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    in512,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [OUT_W-1:0]   out32,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [IDX_W-1:0]   out_idx,
  output logic               busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  logic [0:0]       state;
  logic [IN_W-1:0]  shreg_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             vld_p0;
  logic             last_p0;

  assign vld_p0  = (state == SEND);
  assign last_p0 = vld_p0 && (idx_p0 == LAST_IDX);

  // The block is shifted left on each handshake, so the current word always sits in the top slot.
  assign in_ready  = !reset && (state == IDLE);
  assign out_valid = vld_p0;
  assign out32     = vld_p0 ? shreg_p0[IN_W-1 -: OUT_W] : '0;
  assign out_idx   = idx_p0;
  assign out_last  = last_p0;
  assign busy      = vld_p0;

  // Stage p0: capture, shift-out and word index sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx_p0   <= '0;
      shreg_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg_p0 <= in512;
            idx_p0   <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          // flush outranks a same-cycle handshake: that word is not counted as delivered
          if (flush) begin
            state  <= IDLE;
            idx_p0 <= '0;
          end else if (out_ready) begin
            shreg_p0 <= {shreg_p0[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
            if (last_p0) begin
              state  <= IDLE;
              idx_p0 <= '0;
            end else begin
              idx_p0 <= idx_p0 + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          idx_p0 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_word_streamer.sv
// Directed bench for keccak_word_streamer: a block table streamed with and without
// backpressure, plus hand-written held-input, flush and mid-stream reset sequences.
module tb_keccak_word_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] in512;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out32;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [5:0]   out_idx;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] got [16];

  keccak_word_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .in512     (in512),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out32     (out32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] blk;
    logic [31:0]  w0;
    logic [31:0]  w15;
    bit           stall;
  } vec_t;

  vec_t vecs [6];

  localparam logic [511:0] PAT =
    512'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF_0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;

  function automatic logic [31:0] word_of(input logic [511:0] b, input int i);
    return b[511 - i*32 -: 32];
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents blk, streams all 16 words and checks each against the block's slices.
  task automatic stream(input logic [511:0] blk, input bit stall, input bit hold, input logic [511:0] nxt);
    int n;
    int cyc;
    in512    = blk;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    if (hold) begin
      in512    = nxt;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    chk("cap_in_ready", in_ready, 0);
    chk("cap_busy", busy, 1);
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 200) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      chk("word", out32, word_of(blk, n));
      chk("word_idx", out_idx, n);
      chk("word_last", out_last, (n == 15));
      chk("word_valid", out_valid, 1);
      got[n] = out32;
      tick();
      if (out_ready) n++;
      cyc++;
    end
    out_ready = 1'b0;
    if (n != 16) chk("stream_timeout", n, 16);
    chk("end_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_idx", out_idx, 0);
    chk("end_out32", out32, 0);
  endtask

  initial begin
    vecs[0] = '{blk: PAT, w0: 32'h00001111, w15: 32'hEEEEFFFF, stall: 1'b0};
    vecs[1] = '{blk: PAT, w0: 32'h00001111, w15: 32'hEEEEFFFF, stall: 1'b1};
    vecs[2] = '{blk: {512{1'b1}}, w0: 32'hFFFFFFFF, w15: 32'hFFFFFFFF, stall: 1'b0};
    vecs[3] = '{blk: 512'h1, w0: 32'h00000000, w15: 32'h00000001, stall: 1'b1};
    vecs[4] = '{blk: {1'b1, 511'd0}, w0: 32'h80000000, w15: 32'h00000000, stall: 1'b0};
    vecs[5] = '{blk: {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
                      32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15},
                w0: 32'h00000000, w15: 32'h0000000F, stall: 1'b1};

    reset = 1'b1; in512 = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out32", out32, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    // flush while idle must not disturb anything
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_in_ready", in_ready, 1);
    chk("idle_flush_valid", out_valid, 0);

    foreach (vecs[i]) begin
      stream(vecs[i].blk, vecs[i].stall, 1'b0, '0);
      chk("tbl_w0", got[0], vecs[i].w0);
      chk("tbl_w15", got[15], vecs[i].w15);
    end
    chk("pat_w1", got[1], 32'h00000001);

    // New block held on in_valid during SEND: first block intact, second captured afterwards
    stream(PAT, 1'b1, 1'b1, {512{1'b1}} ^ PAT);
    chk("held_a_w0", got[0], 32'h00001111);
    stream({512{1'b1}} ^ PAT, 1'b0, 1'b0, '0);
    chk("held_b_w0", got[0], 32'hFFFFEEEE);
    chk("held_b_w15", got[15], 32'h11110000);

    // flush at word 5 with out_ready asserted
    in512 = PAT; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("pre_flush_idx", out_idx, 5);
    chk("pre_flush_word", out32, 32'hAAAABBBB);
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_idx", out_idx, 0);
    chk("flush_out32", out32, 0);
    stream(vecs[5].blk, 1'b0, 1'b0, '0);
    chk("after_flush_w0", got[0], 32'h00000000);
    chk("after_flush_w9", got[9], 32'h00000009);

    // reset at word 9
    in512 = vecs[5].blk; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("pre_rst_idx", out_idx, 9);
    chk("pre_rst_word", out32, 32'h00000009);
    reset = 1'b1;
    tick();
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_out32", out32, 0);
    reset = 1'b0; out_ready = 1'b0;
    tick();
    chk("after_rst_in_ready", in_ready, 1);
    stream(PAT, 1'b1, 1'b0, '0);
    chk("after_rst_w0", got[0], 32'h00001111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
